// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls, redirect flushes,
// data-memory freeze with timeout, and EX operand forwarding. Optional: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // ID stage
  input  logic [REG_AW-1:0] rs1_id_i,
  input  logic [REG_AW-1:0] rs2_id_i,
  input  logic              use_rs1_id_i,
  input  logic              use_rs2_id_i,
  // EX stage
  input  logic [REG_AW-1:0] rs1_ex_i,
  input  logic [REG_AW-1:0] rs2_ex_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic              ex_is_load_i,
  input  logic              ex_reg_write_i,
  // MEM / WB stages
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              wb_reg_write_i,
  // Redirect and data memory
  input  logic              redirect_ex_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  // Pipeline control
  output logic              hold_pc_o,
  output logic              hold_ifid_o,
  output logic              bubble_idex_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              freeze_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              mem_err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int unsigned CntW        = 8;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdMem = 2'b01;
  localparam logic [1:0] FwdWb  = 2'b10;

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic            freeze;
  logic            redirect;
  logic            load_use_hit;
  logic            load_use;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  // Hazard detection, ungated by reset
  always_comb begin
    freeze       = dmem_req_i & ~dmem_ready_i;
    redirect     = redirect_ex_i & ~freeze;
    load_use_hit = ex_is_load_i & ex_reg_write_i & (rd_ex_i != '0) &
                   ((use_rs1_id_i & (rs1_id_i == rd_ex_i)) |
                    (use_rs2_id_i & (rs2_id_i == rd_ex_i)));
    // Redirect squashes the dependent instruction, so its stall is moot
    load_use     = load_use_hit & ~freeze & ~redirect_ex_i;
  end

  always_comb begin
    fwd_a = FwdRf;
    if (mem_reg_write_i && (rd_mem_i != '0) && (rd_mem_i == rs1_ex_i)) begin
      fwd_a = FwdMem;
    end else if (wb_reg_write_i && (rd_wb_i != '0) && (rd_wb_i == rs1_ex_i)) begin
      fwd_a = FwdWb;
    end

    fwd_b = FwdRf;
    if (mem_reg_write_i && (rd_mem_i != '0) && (rd_mem_i == rs2_ex_i)) begin
      fwd_b = FwdMem;
    end else if (wb_reg_write_i && (rd_wb_i != '0) && (rd_wb_i == rs2_ex_i)) begin
      fwd_b = FwdWb;
    end
  end

  // Memory wait FSM with timeout watchdog
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      StRun: begin
        if (dmem_req_i && !dmem_ready_i) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (dmem_ready_i) begin
          state_d = StRun;
        end else if (wait_cnt_q == TimeoutLast) begin
          state_d   = StRun;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Controls are forced low while reset is asserted
  always_comb begin
    hold_pc_o     = rst_ni & load_use;
    hold_ifid_o   = rst_ni & load_use;
    bubble_idex_o = rst_ni & load_use;
    flush_ifid_o  = rst_ni & redirect;
    flush_idex_o  = rst_ni & redirect;
    freeze_o      = rst_ni & freeze;
    fwd_a_o       = rst_ni ? fwd_a : FwdRf;
    fwd_b_o       = rst_ni ? fwd_b : FwdRf;
    mem_err_o     = mem_err_q;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze || load_use) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: stalls, redirects, memory wait/timeout,
// forwarding, and the optional HAZARD_PERF_CNT_EN counters.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic       use_rs1_id, use_rs2_id, ex_is_load, ex_reg_write;
  logic       mem_reg_write, wb_reg_write, redirect_ex, dmem_req, dmem_ready;
  logic       hold_pc, hold_ifid, bubble_idex, flush_ifid, flush_idex, freeze, mem_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .REG_AW     (5),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rs1_id_i       (rs1_id),
    .rs2_id_i       (rs2_id),
    .use_rs1_id_i   (use_rs1_id),
    .use_rs2_id_i   (use_rs2_id),
    .rs1_ex_i       (rs1_ex),
    .rs2_ex_i       (rs2_ex),
    .rd_ex_i        (rd_ex),
    .ex_is_load_i   (ex_is_load),
    .ex_reg_write_i (ex_reg_write),
    .rd_mem_i       (rd_mem),
    .mem_reg_write_i(mem_reg_write),
    .rd_wb_i        (rd_wb),
    .wb_reg_write_i (wb_reg_write),
    .redirect_ex_i  (redirect_ex),
    .dmem_req_i     (dmem_req),
    .dmem_ready_i   (dmem_ready),
    .hold_pc_o      (hold_pc),
    .hold_ifid_o    (hold_ifid),
    .bubble_idex_o  (bubble_idex),
    .flush_ifid_o   (flush_ifid),
    .flush_idex_o   (flush_idex),
    .freeze_o       (freeze),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .mem_err_o      (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {hold_pc, hold_ifid, bubble_idex, flush_ifid, flush_idex, freeze}
  function automatic logic [5:0] ctl();
    return {hold_pc, hold_ifid, bubble_idex, flush_ifid, flush_idex, freeze};
  endfunction

  task automatic idle();
    rs1_id = '0; rs2_id = '0; use_rs1_id = 0; use_rs2_id = 0;
    rs1_ex = '0; rs2_ex = '0; rd_ex = '0; ex_is_load = 0; ex_reg_write = 0;
    rd_mem = '0; mem_reg_write = 0; rd_wb = '0; wb_reg_write = 0;
    redirect_ex = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    // Drive conditions that would otherwise activate every output
    redirect_ex = 1; dmem_req = 1; dmem_ready = 0;
    ex_is_load = 1; ex_reg_write = 1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1;
    rd_mem = 5'd7; mem_reg_write = 1; rs1_ex = 5'd7; rs2_ex = 5'd7;
    #1;
    checks++;
    if (ctl() !== 6'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 000000", ctl());
    end
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got %b/%b expected 00/00", fwd_a, fwd_b);
    end
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err);
    end
    do_reset();
    checks++;
    if (ctl() !== 6'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got %b/%b expected 000000/0", ctl(), mem_err);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ex_is_load = 1; ex_reg_write = 1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1;
    #1;
    checks++;
    if (ctl() !== 6'b111000) begin
      errors++; $display("FAIL load_use_rs1: got %b expected 111000", ctl());
    end
    @(negedge clk);
    // Bubble now in EX, load moved to MEM
    ex_is_load = 0; ex_reg_write = 0; rd_ex = '0; rd_mem = 5'd5; mem_reg_write = 1;
    #1;
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL load_use_clear: got %b expected 000000", ctl());
    end
    @(negedge clk);
    idle();
    ex_is_load = 1; ex_reg_write = 1; rd_ex = 5'd9; rs2_id = 5'd9; use_rs2_id = 1;
    rs1_id = 5'd9; use_rs1_id = 0;
    #1;
    checks++;
    if (ctl() !== 6'b111000) begin
      errors++; $display("FAIL load_use_rs2: got %b expected 111000", ctl());
    end
    use_rs2_id = 0;
    #1;
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL load_use_unused_src: got %b expected 000000", ctl());
    end
    use_rs1_id = 1; ex_reg_write = 0;
    #1;
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL load_use_no_write: got %b expected 000000", ctl());
    end
    ex_reg_write = 1; ex_is_load = 0;
    #1;
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL alu_no_stall: got %b expected 000000", ctl());
    end
    idle();
  endtask

  task automatic test_load_x0();
    @(negedge clk);
    idle();
    ex_is_load = 1; ex_reg_write = 1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1;
    #1;
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL load_x0: got %b expected 000000", ctl());
    end
    idle();
  endtask

  task automatic test_redirect();
    @(negedge clk);
    idle();
    redirect_ex = 1;
    #1;
    checks++;
    if (ctl() !== 6'b000110) begin
      errors++; $display("FAIL redirect_only: got %b expected 000110", ctl());
    end
    ex_is_load = 1; ex_reg_write = 1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1;
    #1;
    checks++;
    if (ctl() !== 6'b000110) begin
      errors++; $display("FAIL redirect_over_load_use: got %b expected 000110", ctl());
    end
    dmem_req = 1; dmem_ready = 0;
    #1;
    checks++;
    if (ctl() !== 6'b000001) begin
      errors++; $display("FAIL freeze_over_all: got %b expected 000001", ctl());
    end
    do_reset();
  endtask

  task automatic test_mem_wait();
    int n;
    do_reset();
    @(negedge clk);
    dmem_req = 1; dmem_ready = 0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (freeze === 1'b1) n++;
      @(negedge clk);
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (n !== 3 || freeze !== 1'b0) begin
      errors++; $display("FAIL mem_wait_freeze: got %0d cycles, freeze=%b expected 3, 0", n, freeze);
    end
    @(negedge clk);
    dmem_req = 0; dmem_ready = 0;
    #1;
    checks++;
    if (mem_err !== 1'b0 || freeze !== 1'b0) begin
      errors++; $display("FAIL mem_wait_done: got err=%b freeze=%b expected 0 0", mem_err, freeze);
    end
  endtask

  task automatic test_mem_timeout();
    // Ready in the last allowed wait cycle must not raise the error
    do_reset();
    @(negedge clk);
    dmem_req = 1; dmem_ready = 0;
    repeat (15) @(negedge clk);
    dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_near_miss: got %b expected 0", mem_err);
    end
    do_reset();
    @(negedge clk);
    dmem_req = 1; dmem_ready = 0;
    repeat (15) @(negedge clk);
    checks++;
    if (mem_err !== 1'b0 || freeze !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got err=%b freeze=%b expected 0 1", mem_err, freeze);
    end
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_set: got %b expected 1", mem_err);
    end
    dmem_req = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b expected 1", mem_err);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_async_clear: got %b expected 0", mem_err);
    end
    do_reset();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    idle();
    rd_mem = 5'd7; rd_wb = 5'd7; mem_reg_write = 1; wb_reg_write = 1;
    rs1_ex = 5'd7; rs2_ex = 5'd7;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      errors++; $display("FAIL fwd_mem_wins: got %b/%b expected 01/01", fwd_a, fwd_b);
    end
    mem_reg_write = 0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      errors++; $display("FAIL fwd_wb: got %b/%b expected 10/10", fwd_a, fwd_b);
    end
    rs1_ex = 5'd0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0010) begin
      errors++; $display("FAIL fwd_rs1_x0: got %b/%b expected 00/10", fwd_a, fwd_b);
    end
    rd_mem = 5'd0; rd_wb = 5'd0; mem_reg_write = 1; rs2_ex = 5'd0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++; $display("FAIL fwd_never_x0: got %b/%b expected 00/00", fwd_a, fwd_b);
    end
    rd_mem = 5'd7; rd_wb = 5'd3; rs1_ex = 5'd7; rs2_ex = 5'd3; wb_reg_write = 1;
    dmem_req = 1; dmem_ready = 0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0110 || freeze !== 1'b1) begin
      errors++; $display("FAIL fwd_during_freeze: got %b/%b frz=%b expected 01/10 1",
                         fwd_a, fwd_b, freeze);
    end
    do_reset();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    @(negedge clk);
    ex_is_load = 1; ex_reg_write = 1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1;
    @(negedge clk);
    idle(); redirect_ex = 1;
    @(negedge clk);
    idle(); dmem_req = 1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cnt !== 32'd2 || flush_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_cnt: got %0d/%0d expected 2/1", stall_cnt, flush_cnt);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_load_x0();
    test_redirect();
    test_mem_wait();
    test_mem_timeout();
    test_forwarding();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Detects load-use hazards, taken-branch/jump redirects and data-memory wait states.
- Drives hold/flush controls for the PC, IF/ID and ID/EX pipeline registers.
- Drives the EX-stage operand forwarding selects.
- Sits beside the control unit; consumes decoded register fields per stage.

Parameters:
REG_AW, 5, register address width
MEM_TIMEOUT, 15, max consecutive data-memory wait cycles before the error flag is set (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rs1_id, rs2_id  in  REG_AW  source registers of the instruction in ID
use_rs1_id, use_rs2_id  in  1  ID instruction actually reads rs1/rs2
rs1_ex, rs2_ex  in  REG_AW  source registers of the instruction in EX
rd_ex  in  REG_AW  destination of the EX instruction
ex_is_load, ex_reg_write  in  1  EX instruction is a load / writes rd
rd_mem, mem_reg_write  in  REG_AW, 1  MEM destination and its write enable
rd_wb, wb_reg_write  in  REG_AW, 1  WB destination and its write enable
redirect_ex  in  1  taken branch or JAL/JALR resolved in EX
dmem_req, dmem_ready  in  1  MEM-stage memory request / completion
hold_pc, hold_ifid  out  1  PC and IF/ID keep their value
bubble_idex  out  1  ID/EX loads a NOP (all-zero cword)
flush_ifid, flush_idex  out  1  kill younger instructions
freeze  out  1  every pipeline register holds
fwd_a, fwd_b  out  2  00 regfile, 01 EX/MEM result, 10 MEM/WB result
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst=0, async): state=RUN; wait_cnt=0; mem_err=0. All control outputs evaluate to 0 while in reset.
- FSM states: RUN and MEM_WAIT.
- RUN to MEM_WAIT: dmem_req=1 and dmem_ready=0 at a clock edge.
- MEM_WAIT to RUN: dmem_ready=1, or wait_cnt reaches MEM_TIMEOUT-1. On timeout, also set mem_err=1.
- freeze: asserted combinationally whenever dmem_req=1 and dmem_ready=0, in either state. It deasserts in the same cycle dmem_ready rises, so there is zero extra latency.
- wait_cnt: increments each cycle in MEM_WAIT; clears on any exit.
- mem_err: cleared only by reset.
- Priority, highest first: freeze > redirect > load-use. When freeze=1, all other hold/flush/bubble outputs are 0.
- Redirect: redirect_ex=1 and freeze=0 gives flush_ifid=1 and flush_idex=1 in the same cycle. It overrides any concurrent load-use stall, so hold_pc=0 and the new PC is taken.
- Load-use condition: ex_is_load & ex_reg_write & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
- Load-use response (no freeze, no redirect): hold_pc=hold_ifid=bubble_idex=1 for exactly one cycle. Next cycle the load is in MEM and the condition clears naturally.
- fwd_a: 01 if mem_reg_write & rd_mem!=0 & rd_mem==rs1_ex; else 10 if wb_reg_write & rd_wb!=0 & rd_wb==rs1_ex; else 00.
- fwd_b: same rule using rs2_ex.
- Forwarding: EX/MEM wins over MEM/WB. x0 is never forwarded. fwd_* stay valid during freeze.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and wrapping at 2^32.
- stall_cnt increments each cycle freeze or bubble_idex is 1.
- flush_cnt increments once per cycle with flush_idex=1.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX=lw x5 (ex_is_load=1, rd_ex=5), ID add reads rs1_id=5 -> one cycle hold_pc=hold_ifid=bubble_idex=1, then all 0.
- Load-to-x0: rd_ex=0, rs1_id=0 -> no stall.
- Redirect + load-use in the same cycle -> flush_ifid=flush_idex=1, hold_pc=0, bubble_idex=0.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles, then high -> freeze=1 for exactly 3 cycles, state back to RUN, mem_err=0.
- Memory timeout: dmem_ready held low with MEM_TIMEOUT=15 -> mem_err=1 after 15 wait cycles and stays 1 until rst=0.
- Forwarding: rd_mem=rd_wb=7, both write, rs1_ex=7, rs2_ex=7 -> fwd_a=fwd_b=01. With mem_reg_write=0 -> 10. With rs1_ex=0 -> fwd_a=00.
